instruktionsdekodierer_puffer: RTL

Parametrised decode stage with a TIEFE-entry instruction queue between fetch and execute. It accepts 32-bit instruction words over a valid/ready handshake and decodes the queue head into register indices, immediate, function code and control flags. The decoded fields are held in an output register, so fetch and execute are fully decoupled and one instruction per cycle can be sustained. A Flush input discards everything in flight on a taken jump.

---
 rtl/instruktionsdekodierer_puffer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/instruktionsdekodierer_puffer.sv
// Decode stage with a TIEFE-deep instruction queue and a registered decode output.
// Define INSTRUKTIONSDEKODIERER_GLEITKOMMA_EN to map floating-point operands onto register bank 1.
module instruktionsdekodierer_puffer #(
  parameter int TIEFE          = 4,
  parameter int ZAEHLER_BREITE = $clog2(TIEFE + 1)
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [31:0]               Instruktion,
  input  logic                      EinValid,
  output logic                      EinBereit,
  input  logic                      Flush,
  input  logic                      AusBereit,
  output logic                      AusValid,
  output logic [5:0]                QuellRegister1,
  output logic [5:0]                QuellRegister2,
  output logic [5:0]                ZielRegister,
  output logic [25:0]               IDaten,
  output logic                      ImmediateAktiv,
  output logic [5:0]                FunktionsCode,
  output logic                      JALBefehl,
  output logic                      RelativerSprung,
  output logic                      AbsoluterSprung,
  output logic                      LoadBefehl,
  output logic                      StoreBefehl,
  output logic                      UnbedingterSprungBefehl,
  output logic                      BedingterSprungBefehl,
  output logic                      Sprungbedingung,
  output logic [ZAEHLER_BREITE-1:0] Fuellstand
);

`ifdef INSTRUKTIONSDEKODIERER_GLEITKOMMA_EN
  localparam logic GLEITKOMMA = 1'b1;
`else
  localparam logic GLEITKOMMA = 1'b0;
`endif

  localparam int ZEIGER_BREITE = $clog2(TIEFE);
  localparam logic [ZAEHLER_BREITE-1:0] VOLL = ZAEHLER_BREITE'(TIEFE);

  typedef struct packed {
    logic [5:0]  quell1;
    logic [5:0]  quell2;
    logic [5:0]  ziel;
    logic [25:0] iDaten;
    logic        immAktiv;
    logic [5:0]  funktion;
    logic        jal;
    logic        relativ;
    logic        absolut;
    logic        load;
    logic        store;
    logic        unbedingt;
    logic        bedingt;
    logic        bedingung;
  } dekodiertT;

  function automatic dekodiertT dekodiere(input logic [31:0] i);
    dekodiertT  d;
    logic [5:0] opcode;
    logic [1:0] format;
    logic [4:0] z;
    logic       fp;
    opcode = i[31:26];
    format = i[31:30];
    z      = i[25:21];
    fp     = GLEITKOMMA && (format == 2'b00) && (i[5:4] == 2'b10);
    d      = '0;

    d.quell1 = {fp, i[20:16]};
    if (opcode == 6'b111010)      d.quell2 = {1'b0, z};
    else if (opcode == 6'b111011) d.quell2 = {GLEITKOMMA, z};
    else                          d.quell2 = {fp, i[15:11]};

    if (opcode == 6'b111001 || opcode == 6'b111011 || (fp && i[3:0] < 4'd8))
      d.ziel = {GLEITKOMMA, z};
    else if (format == 2'b00 || format[1])
      d.ziel = {1'b0, z};

    if (format == 2'b01)  d.iDaten = i[25:0];
    else if (format[1])   d.iDaten = {{10{i[15]}}, i[15:0]};
    d.immAktiv = (format == 2'b01) || format[1];

    if (format == 2'b00)                             d.funktion = i[5:0];
    else if (format == 2'b01 || opcode[5:3] == 3'b111) d.funktion = 6'd0;
    else                                             d.funktion = {1'b0, i[30:26]};

    d.jal       = (opcode == 6'b111111);
    d.relativ   = (opcode == 6'b111111) || (opcode == 6'b010000) ||
                  (opcode == 6'b111101) || (opcode == 6'b111110);
    d.absolut   = (opcode == 6'b111100);
    d.load      = (opcode == 6'b111000) || (opcode == 6'b111001);
    d.store     = (opcode == 6'b111010) || (opcode == 6'b111011);
    d.unbedingt = (opcode == 6'b111100) || (opcode == 6'b111111) || (opcode == 6'b010000);
    d.bedingt   = (opcode == 6'b111101) || (opcode == 6'b111110);
    d.bedingung = (opcode == 6'b111101);
    return d;
  endfunction

  logic [31:0]               speicher [TIEFE];
  logic [ZEIGER_BREITE-1:0]  schreibZeiger, leseZeiger;
  logic [ZAEHLER_BREITE-1:0] naechsterStand;
  dekodiertT                 ausDaten;
  logic                      push, pop;

  assign push = EinValid && EinBereit;
  assign pop  = (Fuellstand != '0) && (!AusValid || AusBereit);

  always_comb begin
    naechsterStand = Fuellstand;
    if (push && !pop)      naechsterStand = Fuellstand + 1'b1;
    else if (!push && pop) naechsterStand = Fuellstand - 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (push && !Flush && !Reset) speicher[schreibZeiger] <= Instruktion;
  end

  // Flush leaves the decoded data registers stale; only Reset clears them.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      schreibZeiger <= '0;
      leseZeiger    <= '0;
      Fuellstand    <= '0;
      EinBereit     <= 1'b1;
      AusValid      <= 1'b0;
      ausDaten      <= '0;
    end else if (Flush) begin
      schreibZeiger <= '0;
      leseZeiger    <= '0;
      Fuellstand    <= '0;
      EinBereit     <= 1'b1;
      AusValid      <= 1'b0;
    end else begin
      if (push) schreibZeiger <= schreibZeiger + 1'b1;
      if (pop) begin
        leseZeiger <= leseZeiger + 1'b1;
        ausDaten   <= dekodiere(speicher[leseZeiger]);
        AusValid   <= 1'b1;
      end else if (AusBereit) begin
        AusValid <= 1'b0;
      end
      Fuellstand <= naechsterStand;
      EinBereit  <= (naechsterStand != VOLL);
    end
  end

  assign QuellRegister1          = ausDaten.quell1;
  assign QuellRegister2          = ausDaten.quell2;
  assign ZielRegister            = ausDaten.ziel;
  assign IDaten                  = ausDaten.iDaten;
  assign ImmediateAktiv          = ausDaten.immAktiv;
  assign FunktionsCode           = ausDaten.funktion;
  assign JALBefehl               = ausDaten.jal;
  assign RelativerSprung         = ausDaten.relativ;
  assign AbsoluterSprung         = ausDaten.absolut;
  assign LoadBefehl              = ausDaten.load;
  assign StoreBefehl             = ausDaten.store;
  assign UnbedingterSprungBefehl = ausDaten.unbedingt;
  assign BedingterSprungBefehl   = ausDaten.bedingt;
  assign Sprungbedingung         = ausDaten.bedingung;

endmodule
